// File: rtl/stream_fifo.sv
// Valid/ready circular-buffer FIFO that feeds a downstream register stage.
// The head word is read combinationally from the buffer; nothing on `in` reaches `out` in the same cycle.
module stream_fifo #(
    parameter int width      = 32,
    parameter int depth      = 4,
    parameter int addr_width = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [width-1:0]      in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [width-1:0]      out,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [addr_width:0]   count
);

    localparam logic [addr_width:0] full_count = (addr_width + 1)'(depth);

    logic [width-1:0]      mem [depth];
    logic [addr_width-1:0] wr_ptr;
    logic [addr_width-1:0] rd_ptr;
    logic [addr_width:0]   count_q;
    logic                  push;
    logic                  pop;

    // Qualifying with reset keeps both handshakes dead while reset is held low.
    assign in_ready  = reset && (count_q != full_count);
    assign out_valid = reset && (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign out       = out_valid ? mem[rd_ptr] : '0;
    assign count     = count_q;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo: reset, fill/drain, streaming, random traffic with a scoreboard,
// and asynchronous reset while words are queued.
module tb_stream_fifo;

    logic        clk;
    logic        reset;
    logic [31:0] din;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dout;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  count;

    int          vectors;
    int          miscompares;

    logic [31:0] sb [$];
    int          sent;
    int          received;
    int          cycles;
    bit          push_m;
    bit          pop_m;
    bit          prev_valid;
    bit          prev_push;
    logic [31:0] prev_in;

    stream_fifo #(.width(32), .depth(4), .addr_width(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .in        (din),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out       (dout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        din         = '0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        #2 reset = 1'b0;

        // Held in reset
        sample();
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out", dout, 32'd0);
        step();
        reset = 1'b1;

        // Idle after release
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("idle_out_valid", 32'(out_valid), 32'd0);
            chk("idle_in_ready", 32'(in_ready), 32'd1);
            chk("idle_count", 32'(count), 32'd0);
            chk("idle_out", dout, 32'd0);
            step();
        end

        // Fill to full with out_ready low
        for (int i = 0; i < 4; i++) begin
            din      = 32'h11 * (i + 1);
            in_valid = 1'b1;
            sample();
            chk("fill_in_ready", 32'(in_ready), 32'd1);
            chk("fill_count", 32'(count), 32'(i));
            step();
            chk("fill_head", dout, 32'h11);
            chk("fill_out_valid", 32'(out_valid), 32'd1);
        end
        din = 32'h55;
        sample();
        chk("full_count", 32'(count), 32'd4);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        step();
        in_valid = 1'b0;
        chk("full_ignore_count", 32'(count), 32'd4);
        chk("full_hold_head", dout, 32'h11);

        // Drain
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sample();
            chk("drain_out", dout, 32'h11 * (i + 1));
            chk("drain_out_valid", 32'(out_valid), 32'd1);
            chk("drain_count", 32'(count), 32'(4 - i));
            chk("drain_in_ready", 32'(in_ready), (i == 0) ? 32'd0 : 32'd1);
            step();
        end
        sample();
        chk("drained_out_valid", 32'(out_valid), 32'd0);
        chk("drained_count", 32'(count), 32'd0);
        chk("drained_out", dout, 32'd0);
        step();

        // Continuous streaming 0..19
        in_valid  = 1'b1;
        out_ready = 1'b1;
        din       = 32'd0;
        sample();
        chk("stream_first_out_valid", 32'(out_valid), 32'd0);
        step();
        for (int k = 1; k < 20; k++) begin
            din = 32'(k);
            sample();
            chk("stream_out", dout, 32'(k - 1));
            chk("stream_out_valid", 32'(out_valid), 32'd1);
            chk("stream_count", 32'(count), 32'd1);
            step();
        end
        in_valid = 1'b0;
        sample();
        chk("stream_last", dout, 32'd19);
        chk("stream_last_count", 32'(count), 32'd1);
        step();
        sample();
        chk("stream_empty_count", 32'(count), 32'd0);
        step();

        // Random traffic against a queue scoreboard
        sent       = 0;
        received   = 0;
        cycles     = 0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        prev_valid = 1'b0;
        prev_push  = 1'b0;
        prev_in    = '0;
        while (received < 1000 && cycles < 20000) begin
            cycles++;
            if (!in_valid && sent < 1000 && $urandom_range(1) == 1) begin
                in_valid = 1'b1;
                din      = $urandom;
            end
            out_ready = ($urandom_range(1) == 1);
            if (prev_valid && !prev_push) begin
                chk("rule_valid_held", 32'(in_valid), 32'd1);
                chk("rule_data_stable", din, prev_in);
            end
            sample();
            chk("rand_count", 32'(count), 32'(sb.size()));
            chk("rand_out_valid", 32'(out_valid), 32'(sb.size() != 0));
            chk("rand_in_ready", 32'(in_ready), 32'(sb.size() != 4));
            if (sb.size() != 0) chk("rand_out", dout, sb[0]);
            push_m = in_valid && (sb.size() < 4);
            pop_m  = out_ready && (sb.size() > 0);
            step();
            prev_valid = in_valid;
            prev_push  = push_m;
            prev_in    = din;
            if (pop_m) begin
                void'(sb.pop_front());
                received++;
            end
            if (push_m) begin
                sb.push_back(din);
                sent++;
                in_valid = 1'b0;
            end
        end
        chk("rand_received", 32'(received), 32'd1000);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cycles    = 0;
        while (sb.size() != 0 && cycles < 10) begin
            cycles++;
            sample();
            chk("flush_out", dout, sb[0]);
            step();
            void'(sb.pop_front());
        end
        out_ready = 1'b0;

        // Asynchronous reset with three words queued
        for (int i = 0; i < 3; i++) begin
            din      = 32'(i + 1);
            in_valid = 1'b1;
            step();
        end
        in_valid = 1'b1;
        din      = 32'h99;
        sample();
        chk("pre_rst_count", 32'(count), 32'd3);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_count", 32'(count), 32'd0);
        chk("async_in_ready", 32'(in_ready), 32'd0);
        chk("async_out", dout, 32'd0);
        step();
        step();
        sample();
        chk("in_rst_count", 32'(count), 32'd0);
        step();
        in_valid = 1'b0;
        reset    = 1'b1;
        sample();
        chk("post_rst_count", 32'(count), 32'd0);
        chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        step();
        din      = 32'hAA;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        sample();
        chk("post_rst_first_out", dout, 32'hAA);
        chk("post_rst_first_count", 32'(count), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
